encrypter_multi: RTL

Parametrised, handshaked encryption stage that succeeds the fixed 60-bit, four-function encrypter. It accepts one plaintext word per transfer and derives a per-word key from an internal reseedable Galois LFSR. It applies one of four encryption functions, chosen by a forced or LFSR-driven mode, and emits a registered tagged ciphertext word `{func_id, key, cipher}`. It sits between the plaintext source and the channel/serialiser; the tag carries everything the decrypter needs.

---
 rtl/encrypter_multi_if.sv | 27 ++
 rtl/encrypter_multi.sv | 100 ++++++++++
 2 files changed

// File: rtl/encrypter_multi_if.sv
// Handshake bundle for encrypter_multi: plaintext in, tagged ciphertext out,
// plus mode / reseed controls and the accepted-word counter.
interface encrypter_multi_if #(
  parameter int DATA_W = 60,
  parameter int KEY_W  = 16
);
  logic [2:0]              mode;
  logic                    seed_load;
  logic [KEY_W-1:0]        seed_val;
  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_W-1:0]       in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_W+KEY_W+1:0] out_data;
  logic [15:0]             word_cnt;

  modport master (
    output mode, seed_load, seed_val, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, word_cnt
  );

  modport slave (
    input  mode, seed_load, seed_val, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, word_cnt
  );
endinterface

// File: rtl/encrypter_multi.sv
// One-stage handshaked encrypter: per-word key from a reseedable Galois LFSR,
// one of four ciphers, registered output tagged {func_id, key, cipher}.
module encrypter_multi #(
  parameter int               DATA_W    = 60,
  parameter int               KEY_W     = 16,
  parameter logic [KEY_W-1:0] LFSR_TAPS = 16'hB400,
  parameter logic [KEY_W-1:0] SEED      = 16'hACE1
) (
  input  logic              Clk,
  input  logic              Rst,
  encrypter_multi_if.slave  bus
);

  localparam int OUT_W = DATA_W + KEY_W + 2;
  localparam int REP   = (DATA_W + KEY_W - 1) / KEY_W;

  logic                 r_out_valid;
  logic [OUT_W-1:0]     r_out_data;
  logic [KEY_W-1:0]     r_lfsr;
  logic [15:0]          r_word_cnt;

  logic                 w_in_ready;
  logic                 w_accept;
  logic [REP*KEY_W-1:0] w_rep;
  logic [DATA_W-1:0]    w_ks;
  logic [1:0]           w_func;
  logic [31:0]          w_rot_amt;
  logic [2*DATA_W-1:0]  w_dd;
  logic [DATA_W-1:0]    w_rot;
  logic [DATA_W-1:0]    w_rev;
  logic [DATA_W-1:0]    w_cipher;
  logic [KEY_W-1:0]     w_lfsr_adv;
  logic [KEY_W-1:0]     w_lfsr_next;
  logic [KEY_W-1:0]     w_seed_new;

  assign w_in_ready = !r_out_valid || bus.out_ready;
  assign w_accept   = bus.in_valid && w_in_ready;

  // Keystream: key repeated from the LSB, top copy truncated.
  assign w_rep = {REP{r_lfsr}};
  assign w_ks  = w_rep[DATA_W-1:0];

  assign w_func = bus.mode[2] ? r_lfsr[KEY_W-1:KEY_W-2] : bus.mode[1:0];

  // Rotate-left via a doubled word; upper half is the rotated value.
  assign w_rot_amt = 32'(r_lfsr) % 32'(DATA_W);
  assign w_dd      = {bus.in_data, bus.in_data} << w_rot_amt;
  assign w_rot     = w_dd[2*DATA_W-1:DATA_W];

  genvar gi;
  generate
    for (gi = 0; gi < DATA_W; gi++) begin : g_rev
      assign w_rev[gi] = bus.in_data[DATA_W-1-gi];
    end
  endgenerate

  always_comb begin
    w_cipher = '0;
    case (w_func)
      2'd0:    w_cipher = bus.in_data ^ w_ks;
      2'd1:    w_cipher = w_rot ^ w_ks;
      2'd2:    w_cipher = bus.in_data + w_ks;
      default: w_cipher = w_rev ^ w_ks;
    endcase
  end

  // Zero guard keeps the LFSR out of its lock-up state for any tap choice.
  assign w_lfsr_adv  = (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_TAPS : '0);
  assign w_lfsr_next = (w_lfsr_adv == '0) ? SEED : w_lfsr_adv;
  assign w_seed_new  = (bus.seed_val == '0) ? SEED : bus.seed_val;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_lfsr      <= SEED;
      r_word_cnt  <= '0;
    end else begin
      if (w_accept) begin
        r_out_data  <= {w_func, r_lfsr, w_cipher};
        r_out_valid <= 1'b1;
        r_word_cnt  <= r_word_cnt + 16'd1;
      end else if (r_out_valid && bus.out_ready) begin
        r_out_valid <= 1'b0;
      end

      if (bus.seed_load) begin
        r_lfsr <= w_seed_new;
      end else if (w_accept) begin
        r_lfsr <= w_lfsr_next;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.word_cnt  = r_word_cnt;

endmodule
